// File: rtl/if_prefetch_stage_pkg.sv
// Shared constants for the instruction-fetch prefetch stage.
package if_prefetch_stage_pkg;

    localparam int          IF_DATA_WIDTH           = 32;
    localparam int          IF_MEM_ADDR_INSTR_WIDTH = 16;
    // addi x0, x0, 0
    localparam logic [31:0] IF_NOP_INSTR            = 32'h0000_0013;
    localparam int          IF_PC_INC               = 4;

endpackage

// File: rtl/if_prefetch_fifo.sv
// Prefetch queue: synchronous FIFO holding {pc, instruction} pairs, head visible
// combinationally. Clear wins over push/pop; push on full and pop on empty are ignored.
module if_prefetch_fifo
    import if_prefetch_stage_pkg::*;
#(
    parameter int WIDTH = 2 * IF_DATA_WIDTH,
    parameter int DEPTH = 4
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic                       push_i,
    input  logic                       pop_i,
    input  logic                       clear_i,
    input  logic [WIDTH-1:0]           data_i,
    output logic [WIDTH-1:0]           data_o,
    output logic                       empty_o,
    output logic                       full_o,
    output logic [$clog2(DEPTH+1)-1:0] count_o
);

    localparam int PW = $clog2(DEPTH);
    localparam int CW = $clog2(DEPTH + 1);

    logic [WIDTH-1:0] mem_q [DEPTH];
    logic [PW-1:0]    wptr_q, wptr_d;
    logic [PW-1:0]    rptr_q, rptr_d;
    logic [CW-1:0]    count_q, count_d;
    logic             push_ok, pop_ok;

    assign empty_o = (count_q == '0);
    assign full_o  = (32'(count_q) == DEPTH);
    assign count_o = count_q;
    assign data_o  = mem_q[rptr_q];
    assign push_ok = push_i && !full_o && !clear_i;
    assign pop_ok  = pop_i && !empty_o && !clear_i;

    // Next pointer/occupancy; pointers wrap naturally because DEPTH is a power of two.
    always_comb begin
        wptr_d  = wptr_q;
        rptr_d  = rptr_q;
        count_d = count_q;
        if (clear_i) begin
            wptr_d  = '0;
            rptr_d  = '0;
            count_d = '0;
        end else begin
            if (push_ok) wptr_d = wptr_q + PW'(1);
            if (pop_ok)  rptr_d = rptr_q + PW'(1);
            case ({push_ok, pop_ok})
                2'b10:   count_d = count_q + CW'(1);
                2'b01:   count_d = count_q - CW'(1);
                default: count_d = count_q;
            endcase
        end
    end

    // Control state is reset; storage is not, since empty masks it.
    always_ff @(posedge clk) begin
        if (rst) begin
            wptr_q  <= '0;
            rptr_q  <= '0;
            count_q <= '0;
        end else begin
            wptr_q  <= wptr_d;
            rptr_q  <= rptr_d;
            count_q <= count_d;
        end
    end

    // Entry storage.
    always_ff @(posedge clk) begin
        if (push_ok) mem_q[wptr_q] <= data_i;
    end

endmodule

// File: rtl/if_prefetch_stage.sv
// Instruction-fetch stage: issues pipelined req/gnt fetches under a credit rule,
// queues in-order responses with their PC, and hands one instruction per cycle to
// decode. A branch/jump flushes the queue and discards responses still in flight.
module if_prefetch_stage
    import if_prefetch_stage_pkg::*;
#(
    parameter int                    DATA_WIDTH      = IF_DATA_WIDTH,
    parameter int                    ADDR_WIDTH      = IF_MEM_ADDR_INSTR_WIDTH,
    parameter int                    FIFO_DEPTH      = 4,
    parameter int                    MAX_OUTSTANDING = 2,
    parameter logic [DATA_WIDTH-1:0] RESET_PC        = '0,
    parameter logic [DATA_WIDTH-1:0] NOP_INSTR       = DATA_WIDTH'(IF_NOP_INSTR)
) (
    input  logic                            clk,
    input  logic                            rst,
    input  logic                            brj_i,
    input  logic [DATA_WIDTH-1:0]           brj_pc_i,
    input  logic                            stall_i,
    output logic                            imem_req_o,
    output logic [ADDR_WIDTH-1:0]           imem_addr_o,
    input  logic                            imem_gnt_i,
    input  logic                            imem_rvalid_i,
    input  logic [DATA_WIDTH-1:0]           imem_rdata_i,
    output logic                            d_valid_o,
    output logic [DATA_WIDTH-1:0]           d_instruction_o,
    output logic [DATA_WIDTH-1:0]           d_pc_o,
    output logic [DATA_WIDTH-1:0]           d_pc4_o,
    output logic [$clog2(FIFO_DEPTH+1)-1:0] fifo_count_o
);

    localparam int                    OW      = $clog2(MAX_OUTSTANDING + 1);
    localparam int                    CW      = $clog2(FIFO_DEPTH + 1);
    localparam logic [DATA_WIDTH-1:0] PC_STEP = DATA_WIDTH'(IF_PC_INC);

    logic [DATA_WIDTH-1:0]   fetch_pc_q, fetch_pc_d;
    logic [DATA_WIDTH-1:0]   resp_pc_q, resp_pc_d;
    logic [OW-1:0]           outstanding_q, outstanding_d;
    logic [OW-1:0]           discard_q, discard_d;
    logic                    issue, rsp_take, rsp_drop;
    logic                    fifo_push, fifo_pop, fifo_empty, fifo_full;
    logic [CW-1:0]           fifo_count;
    logic [2*DATA_WIDTH-1:0] fifo_head;
    logic [DATA_WIDTH-1:0]   head_pc, head_instr;

    // Credit rule: queued plus in-flight never exceeds the queue depth, so a
    // response always has a slot waiting for it.
    assign imem_req_o  = !rst && !brj_i
                         && (32'(outstanding_q) < MAX_OUTSTANDING)
                         && (32'(fifo_count) + 32'(outstanding_q) < FIFO_DEPTH);
    assign imem_addr_o = fetch_pc_q[ADDR_WIDTH-1:0];
    assign issue       = imem_req_o && imem_gnt_i;

    // An rvalid with nothing outstanding is a protocol violation and is ignored.
    assign rsp_take    = imem_rvalid_i && (outstanding_q != '0);
    assign rsp_drop    = rsp_take && (discard_q != '0);
    assign fifo_push   = rsp_take && !rsp_drop && !brj_i && !fifo_full;
    assign fifo_pop    = d_valid_o && !stall_i;

    assign head_pc         = fifo_head[2*DATA_WIDTH-1:DATA_WIDTH];
    assign head_instr      = fifo_head[DATA_WIDTH-1:0];
    assign d_valid_o       = !fifo_empty && !brj_i;
    assign d_instruction_o = d_valid_o ? head_instr : NOP_INSTR;
    assign d_pc_o          = d_valid_o ? head_pc : '0;
    assign d_pc4_o         = d_valid_o ? head_pc + PC_STEP : '0;
    assign fifo_count_o    = fifo_count;

    if_prefetch_fifo #(
        .WIDTH (2 * DATA_WIDTH),
        .DEPTH (FIFO_DEPTH)
    ) u_fifo (
        .clk     (clk),
        .rst     (rst),
        .push_i  (fifo_push),
        .pop_i   (fifo_pop),
        .clear_i (brj_i),
        .data_i  ({resp_pc_q, imem_rdata_i}),
        .data_o  (fifo_head),
        .empty_o (fifo_empty),
        .full_o  (fifo_full),
        .count_o (fifo_count)
    );

    // Next-state for fetch/response PCs and the in-flight/discard counters.
    always_comb begin
        fetch_pc_d    = fetch_pc_q;
        resp_pc_d     = resp_pc_q;
        outstanding_d = outstanding_q;
        discard_d     = discard_q;

        case ({issue, rsp_take})
            2'b10:   outstanding_d = outstanding_q + OW'(1);
            2'b01:   outstanding_d = outstanding_q - OW'(1);
            default: outstanding_d = outstanding_q;
        endcase

        if (brj_i) begin
            fetch_pc_d = brj_pc_i;
            resp_pc_d  = brj_pc_i;
            // Every request still in flight after this edge belongs to the old
            // path; a response retiring this cycle (kept or already marked for
            // dropping) leaves one fewer behind.
            discard_d  = outstanding_q - OW'(rsp_take);
        end else begin
            if (issue)     fetch_pc_d = fetch_pc_q + PC_STEP;
            if (fifo_push) resp_pc_d  = resp_pc_q + PC_STEP;
            if (rsp_drop)  discard_d  = discard_q - OW'(1);
        end
    end

    // Fetch-side state registers.
    always_ff @(posedge clk) begin
        if (rst) begin
            fetch_pc_q    <= RESET_PC;
            resp_pc_q     <= RESET_PC;
            outstanding_q <= '0;
            discard_q     <= '0;
        end else begin
            fetch_pc_q    <= fetch_pc_d;
            resp_pc_q     <= resp_pc_d;
            outstanding_q <= outstanding_d;
            discard_q     <= discard_d;
        end
    end

endmodule

// File: tb/tb_if_prefetch_stage.sv
// Directed and randomized bench for if_prefetch_stage with an in-order memory model.
module tb_if_prefetch_stage;

    localparam logic [31:0] NOP = 32'h0000_0013;

    logic        clk = 1'b0;
    logic        rst;
    logic        brj_i;
    logic [31:0] brj_pc_i;
    logic        stall_i;
    logic        imem_req_o;
    logic [15:0] imem_addr_o;
    logic        imem_gnt_i;
    logic        imem_rvalid_i;
    logic [31:0] imem_rdata_i;
    logic        d_valid_o;
    logic [31:0] d_instruction_o;
    logic [31:0] d_pc_o;
    logic [31:0] d_pc4_o;
    logic [2:0]  fifo_count_o;

    int          n_cmp = 0;
    int          n_err = 0;
    int          cyc   = 0;
    int          lat   = 1;
    bit          rnd   = 1'b0;
    logic [15:0] q_addr [$];
    int          q_due  [$];
    logic [31:0] exp_pc;
    bit          seen_req;
    bit          found;

    if_prefetch_stage #(
        .DATA_WIDTH      (32),
        .ADDR_WIDTH      (16),
        .FIFO_DEPTH      (4),
        .MAX_OUTSTANDING (2),
        .RESET_PC        (32'h0),
        .NOP_INSTR       (NOP)
    ) dut (
        .clk             (clk),
        .rst             (rst),
        .brj_i           (brj_i),
        .brj_pc_i        (brj_pc_i),
        .stall_i         (stall_i),
        .imem_req_o      (imem_req_o),
        .imem_addr_o     (imem_addr_o),
        .imem_gnt_i      (imem_gnt_i),
        .imem_rvalid_i   (imem_rvalid_i),
        .imem_rdata_i    (imem_rdata_i),
        .d_valid_o       (d_valid_o),
        .d_instruction_o (d_instruction_o),
        .d_pc_o          (d_pc_o),
        .d_pc4_o         (d_pc4_o),
        .fifo_count_o    (fifo_count_o)
    );

    always #5 clk = ~clk;

    function automatic logic [31:0] mem_word(input logic [15:0] a);
        return {16'hC0DE, a};
    endfunction

    task automatic check_val(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        if (obs !== exp) begin
            n_err++;
            $display("FAIL %s: got %h, expected %h", tag, obs, exp);
        end
    endtask

    task automatic settle();
        #1;
    endtask

    // Record the handshake at the falling edge, then drive the memory response
    // for the next cycle just after the rising edge.
    task automatic step();
        @(negedge clk);
        if (rst) begin
            q_addr.delete();
            q_due.delete();
        end else if (imem_req_o && imem_gnt_i) begin
            q_addr.push_back(imem_addr_o);
            q_due.push_back(cyc + (rnd ? int'($urandom_range(1, 5)) : lat));
        end
        @(posedge clk);
        #1;
        cyc++;
        imem_gnt_i = rnd ? ($urandom_range(0, 9) < 7) : 1'b1;
        if (q_addr.size() > 0 && q_due[0] <= cyc) begin
            imem_rvalid_i = 1'b1;
            imem_rdata_i  = mem_word(q_addr.pop_front());
            void'(q_due.pop_front());
        end else begin
            imem_rvalid_i = 1'b0;
            imem_rdata_i  = 32'hDEAD_BEEF;
        end
    endtask

    task automatic wait_valid(input string tag);
        bit ok;
        ok = 1'b0;
        for (int i = 0; i < 30; i++) begin
            settle();
            if (d_valid_o) begin
                ok = 1'b1;
                break;
            end
            step();
        end
        check_val({tag, "_timeout"}, 32'(ok), 32'd1);
    endtask

    initial begin
        rst = 1'b1; brj_i = 1'b0; brj_pc_i = '0; stall_i = 1'b0;
        imem_gnt_i = 1'b1; imem_rvalid_i = 1'b0; imem_rdata_i = '0;
        @(posedge clk);
        #1;
        step();
        step();

        // Reset state
        settle();
        check_val("rst_req",   32'(imem_req_o),   32'd0);
        check_val("rst_valid", 32'(d_valid_o),    32'd0);
        check_val("rst_instr", d_instruction_o,   NOP);
        check_val("rst_pc",    d_pc_o,            32'd0);
        check_val("rst_pc4",   d_pc4_o,           32'd0);
        check_val("rst_count", 32'(fifo_count_o), 32'd0);
        rst = 1'b0;

        // Zero-wait memory: first valid output two cycles after the first grant
        settle();
        check_val("c0_req",   32'(imem_req_o),  32'd1);
        check_val("c0_addr",  32'(imem_addr_o), 32'd0);
        check_val("c0_valid", 32'(d_valid_o),   32'd0);
        step();
        settle();
        check_val("c1_valid", 32'(d_valid_o),   32'd0);
        check_val("c1_addr",  32'(imem_addr_o), 32'd4);
        step();
        settle();
        check_val("c2_count", 32'(fifo_count_o), 32'd1);
        for (int k = 0; k < 6; k++) begin
            settle();
            check_val("stream_valid", 32'(d_valid_o), 32'd1);
            check_val("stream_pc",    d_pc_o,          32'(4 * k));
            check_val("stream_instr", d_instruction_o, mem_word(16'(4 * k)));
            check_val("stream_pc4",   d_pc4_o,         32'(4 * k + 4));
            step();
        end

        // Stall: outputs hold, queue fills to depth, requests stop
        stall_i = 1'b1;
        for (int i = 0; i < 10; i++) begin
            settle();
            check_val("stall_hold_pc",    d_pc_o,          32'd24);
            check_val("stall_hold_instr", d_instruction_o, mem_word(16'd24));
            step();
        end
        settle();
        check_val("stall_count", 32'(fifo_count_o), 32'd4);
        check_val("stall_noreq", 32'(imem_req_o),   32'd0);
        stall_i = 1'b0;
        for (int k = 0; k < 6; k++) begin
            settle();
            check_val("resume_valid", 32'(d_valid_o), 32'd1);
            check_val("resume_pc",    d_pc_o,         32'(24 + 4 * k));
            step();
        end

        // Reset mid-stream with a full queue
        stall_i = 1'b1;
        repeat (8) step();
        settle();
        check_val("prerst_count", 32'(fifo_count_o), 32'd4);
        lat = 3;
        stall_i = 1'b0;
        rst = 1'b1;
        step();
        rst = 1'b0;
        settle();
        check_val("midrst_valid", 32'(d_valid_o),    32'd0);
        check_val("midrst_instr", d_instruction_o,   NOP);
        check_val("midrst_count", 32'(fifo_count_o), 32'd0);
        check_val("midrst_req",   32'(imem_req_o),   32'd1);
        check_val("midrst_addr",  32'(imem_addr_o),  32'd0);
        step();

        // Branch with two requests in flight (3-cycle memory latency)
        settle();
        check_val("brj_c1_addr", 32'(imem_addr_o), 32'd4);
        step();
        settle();
        check_val("brj_out_limit", 32'(imem_req_o), 32'd0);
        brj_i = 1'b1;
        brj_pc_i = 32'h0000_0100;
        settle();
        check_val("brj_valid", 32'(d_valid_o),  32'd0);
        check_val("brj_instr", d_instruction_o, NOP);
        check_val("brj_req",   32'(imem_req_o), 32'd0);
        step();
        brj_i = 1'b0;
        seen_req = 1'b0;
        found = 1'b0;
        for (int i = 0; i < 20; i++) begin
            settle();
            if (imem_req_o && !seen_req) begin
                seen_req = 1'b1;
                check_val("brj_first_addr", 32'(imem_addr_o), 32'h100);
            end
            if (d_valid_o) begin
                found = 1'b1;
                break;
            end
            step();
        end
        check_val("brj_found", 32'(found), 32'd1);
        check_val("brj_pc",    d_pc_o,          32'h100);
        check_val("brj_data",  d_instruction_o, mem_word(16'h100));
        check_val("brj_pc4",   d_pc4_o,         32'h104);
        step();

        // PC wrap-around
        lat = 1;
        brj_i = 1'b1;
        brj_pc_i = 32'hFFFF_FFFC;
        step();
        brj_i = 1'b0;
        wait_valid("wrap1");
        check_val("wrap1_pc",    d_pc_o,          32'hFFFF_FFFC);
        check_val("wrap1_pc4",   d_pc4_o,         32'h0);
        check_val("wrap1_instr", d_instruction_o, mem_word(16'hFFFC));
        step();
        wait_valid("wrap2");
        check_val("wrap2_pc",    d_pc_o,          32'h0);
        check_val("wrap2_pc4",   d_pc4_o,         32'h4);
        check_val("wrap2_instr", d_instruction_o, mem_word(16'h0));
        step();

        // Random latency/grant/stall/branch against a PC-stream reference
        rnd = 1'b1;
        exp_pc = '0;
        for (int i = 0; i < 3000; i++) begin
            stall_i  = ($urandom_range(0, 9) < 3);
            brj_i    = (i == 0) || ($urandom_range(0, 99) < 3);
            brj_pc_i = $urandom() & 32'hFFFF_FFFC;
            settle();
            if (brj_i) begin
                check_val("rnd_brj_valid", 32'(d_valid_o), 32'd0);
                exp_pc = brj_pc_i;
            end else if (d_valid_o && !stall_i) begin
                check_val("rnd_pc",    d_pc_o,          exp_pc);
                check_val("rnd_instr", d_instruction_o, mem_word(exp_pc[15:0]));
                check_val("rnd_pc4",   d_pc4_o,         exp_pc + 32'd4);
                exp_pc = exp_pc + 32'd4;
            end
            check_val("rnd_outstanding_le_max",
                      32'((q_addr.size() + int'(imem_rvalid_i)) <= 2), 32'd1);
            check_val("rnd_count_le_depth", 32'(fifo_count_o <= 3'd4), 32'd1);
            step();
        end
        brj_i = 1'b0;
        stall_i = 1'b0;
        rnd = 1'b0;

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
